// File: rtl/onehot_pkg.sv
// onehot_pkg: shared types and constants for the one-hot decoder/encoder family.
//   ONEHOT_WIDTH   default number of one-hot lines, shared with the decoder
//   ONEHOT_IDX_W   index width matching ONEHOT_WIDTH
//   buf_state_e    occupancy of the encoder's 2-entry output buffer
//   onehot_entry_t one buffered result {idx, err} at the default width
package onehot_pkg;
    localparam int ONEHOT_WIDTH = 4;
    localparam int ONEHOT_IDX_W = $clog2(ONEHOT_WIDTH);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
    typedef struct packed {
        logic [ONEHOT_IDX_W-1:0] idx;
        logic                    err;
    } onehot_entry_t;
endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc: combinational priority encoder with one-hot legality flag.
//   code  in   WIDTH  candidate one-hot word
//   idx   out  IDX_W  position of the highest set bit, 0 when no bit is set
//   err   out  1      word is zero-hot or multi-hot
module onehot_prio_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic [IDX_W-1:0] idx,
    output logic             err
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (code[i]) idx = IDX_W'(i);
    end
    // code & (code-1) clears the lowest set bit; anything left means multi-hot
    assign err = ~|code | |(code & (code - WIDTH'(1)));
endmodule

// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: streaming one-hot to binary encoder with 2-entry output buffer.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_code      upstream word, accepted when in_ready is high
//   in_ready              buffer has room (EMPTY or ONE)
//   out_valid/out_idx/out_err  head of the buffer, popped when out_ready is high
//   err_count             saturating count of accepted illegal words
module onehot_encoder_stream
    import onehot_pkg::*;
#(
    parameter int WIDTH = ONEHOT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_code,
    output logic             in_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count
);
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             err;
    } buf_entry_t;

    buf_state_e state_q, state_d;
    buf_entry_t head_q, head_d, tail_q, tail_d, enc;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic accept, pop;

    onehot_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
        .code(in_code),
        .idx (enc.idx),
        .err (enc.err)
    );

    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign out_idx   = head_q.idx;
    assign out_err   = head_q.err;
    assign err_count = cnt_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                head_d  = enc;
            end
            ONE: begin
                // accept+pop replaces the head in place and stays in ONE
                if (accept && pop) head_d = enc;
                else if (accept) begin
                    state_d = FULL;
                    tail_d  = enc;
                end else if (pop) state_d = EMPTY;
            end
            FULL: if (pop) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
        cnt_d = (accept && enc.err && cnt_q != {ERR_W{1'b1}}) ? cnt_q + ERR_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: table-driven checks of the streaming one-hot encoder.
module tb_onehot_encoder_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_code = '0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_err;
    logic [1:0] out_idx;
    logic [7:0] err_count;

    logic       s_valid = 1'b0;
    logic [3:0] s_code = '0;
    logic       s_in_ready, s_out_valid, s_out_err;
    logic [1:0] s_out_idx;
    logic [1:0] s_err_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    onehot_encoder_stream u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .out_valid(out_valid), .out_idx(out_idx),
        .out_err(out_err), .out_ready(out_ready), .err_count(err_count)
    );

    onehot_encoder_stream #(.ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_code(s_code),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_idx(s_out_idx),
        .out_err(s_out_err), .out_ready(1'b1), .err_count(s_err_count)
    );

    typedef struct {
        logic       vld;
        logic [3:0] code;
        logic       ordy;
        logic       e_valid;
        logic [1:0] e_idx;
        logic       e_err;
        logic       e_rdy;
        logic [7:0] e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        // legal stream, out_ready high: one result per cycle, one cycle after accept
        vt.push_back('{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'd0});
        vt.push_back('{1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 8'd0});
        vt.push_back('{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'd0});
        vt.push_back('{1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 8'd0});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd0});
        // illegal codes
        vt.push_back('{1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 8'd1});
        vt.push_back('{1'b1, 4'b1010, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 8'd2});
        vt.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2});
        // back-pressure: three offered, two taken, in order on release
        vt.push_back('{1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b1, 4'b0100, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd2});
        vt.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd2});
        vt.push_back('{1'b1, 4'b1000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b1, 4'b1000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 8'd2});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2});
        // simultaneous accept and pop while in ONE
        vt.push_back('{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b0, 4'b0001, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2});

        // reset values
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_err_count", err_count, 0);
        #10 rst_n = 1'b1;

        foreach (vt[i]) begin
            in_valid  = vt[i].vld;
            in_code   = vt[i].code;
            out_ready = vt[i].ordy;
            tick();
            chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_valid);
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_out_idx", i), out_idx, vt[i].e_idx);
                chk($sformatf("v%0d_out_err", i), out_err, vt[i].e_err);
            end
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_err_count", i), err_count, vt[i].e_cnt);
        end

        // saturation with a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_code  = 4'b0000;
            tick();
            chk($sformatf("sat%0d_err_count", k), s_err_count, (k < 3) ? k + 1 : 3);
        end
        s_valid = 1'b0;

        // mid-operation reset while FULL
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_code   = 4'b0100;
        tick();
        in_code = 4'b0011;
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_err_count", err_count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_out_idx", out_idx, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_out_valid", out_valid, 0);
        in_valid = 1'b1;
        in_code  = 4'b1000;
        tick();
        in_valid = 1'b0;
        chk("post_rst_word_valid", out_valid, 1);
        chk("post_rst_word_idx", out_idx, 3);
        tick();
        chk("post_rst_drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
